// File: rtl/mcctrl.sv
// rtl/mcctrl.sv - multi-cycle MIPS-subset control FSM
module mcctrl #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       MemRead,
    output logic       EXTOp,
    output logic [2:0] ALUOp,
    output logic [1:0] NPCOp,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [1:0] GPRSel,
    output logic [1:0] WDSel,
    output logic [2:0] state,
    output logic       illegal
);

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        DCODE = 3'd1,
        EXE   = 3'd2,
        MEM   = 3'd3,
        WB    = 3'd4
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b001, ALU_SUB = 3'b010, ALU_AND = 3'b011,
                           ALU_OR  = 3'b100, ALU_SLT = 3'b101, ALU_SLL = 3'b110,
                           ALU_SRL = 3'b111;

    state_t r_state;
    state_t w_next;

    logic w_ready;
    logic w_rtype, w_addu, w_subu, w_and, w_or, w_slt, w_sll, w_srl, w_jr;
    logic w_lw, w_sw, w_beq, w_bne, w_addi, w_ori, w_j, w_jal;
    logic w_r_alu, w_legal;
    logic [2:0] w_aluop;
    logic w_ext, w_srca, w_srcb;

    assign w_ready = MEM_WAIT_EN ? mem_ready : 1'b1;

    assign w_rtype = (Op == 6'b000000);
    assign w_addu  = w_rtype && (Funct == 6'b100001);
    assign w_subu  = w_rtype && (Funct == 6'b100011);
    assign w_and   = w_rtype && (Funct == 6'b100100);
    assign w_or    = w_rtype && (Funct == 6'b100101);
    assign w_slt   = w_rtype && (Funct == 6'b101010);
    assign w_sll   = w_rtype && (Funct == 6'b000000);
    assign w_srl   = w_rtype && (Funct == 6'b000010);
    assign w_jr    = w_rtype && (Funct == 6'b001000);
    assign w_lw    = (Op == 6'b100011);
    assign w_sw    = (Op == 6'b101011);
    assign w_beq   = (Op == 6'b000100);
    assign w_bne   = (Op == 6'b000101);
    assign w_addi  = (Op == 6'b001000);
    assign w_ori   = (Op == 6'b001101);
    assign w_j     = (Op == 6'b000010);
    assign w_jal   = (Op == 6'b000011);

    assign w_r_alu = w_addu | w_subu | w_and | w_or | w_slt | w_sll | w_srl;
    assign w_legal = w_r_alu | w_jr | w_lw | w_sw | w_beq | w_bne | w_addi | w_ori | w_j | w_jal;

    // ALU controls depend only on the instruction, so EXE/MEM/WB all reuse them
    always_comb begin
        w_aluop = 3'b000;
        if (w_addu | w_lw | w_sw | w_addi)      w_aluop = ALU_ADD;
        else if (w_subu | w_beq | w_bne)        w_aluop = ALU_SUB;
        else if (w_and)                         w_aluop = ALU_AND;
        else if (w_or | w_ori)                  w_aluop = ALU_OR;
        else if (w_slt)                         w_aluop = ALU_SLT;
        else if (w_sll)                         w_aluop = ALU_SLL;
        else if (w_srl)                         w_aluop = ALU_SRL;
    end

    assign w_ext  = w_lw | w_sw | w_beq | w_bne | w_addi;
    assign w_srca = w_sll | w_srl;
    assign w_srcb = w_lw | w_sw | w_addi | w_ori;

    always_ff @(posedge clk) begin
        if (rst) r_state <= FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = FETCH;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        EXTOp    = 1'b0;
        ALUOp    = 3'b000;
        NPCOp    = 2'b00;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 1'b0;
        GPRSel   = 2'b00;
        WDSel    = 2'b00;
        illegal  = 1'b0;
        if (!rst) begin
            case (r_state)
                FETCH: begin
                    MemRead = 1'b1;
                    if (w_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        w_next  = DCODE;
                    end else begin
                        w_next  = FETCH;
                    end
                end
                DCODE: begin
                    if (w_j) begin
                        PCWrite = 1'b1;
                        NPCOp   = 2'b10;
                    end else if (w_jal) begin
                        // link value is the PC already advanced in FETCH
                        PCWrite  = 1'b1;
                        NPCOp    = 2'b10;
                        RegWrite = 1'b1;
                        GPRSel   = 2'b10;
                        WDSel    = 2'b10;
                    end else if (w_jr) begin
                        PCWrite = 1'b1;
                        NPCOp   = 2'b11;
                    end else if (w_legal) begin
                        w_next  = EXE;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                EXE: begin
                    EXTOp   = w_ext;
                    ALUOp   = w_aluop;
                    ALUSrcA = w_srca;
                    ALUSrcB = w_srcb;
                    if (w_beq | w_bne) begin
                        NPCOp   = 2'b01;
                        PCWrite = w_beq ? Zero : ~Zero;
                    end else if (w_lw | w_sw) begin
                        w_next  = MEM;
                    end else if (w_r_alu | w_addi | w_ori) begin
                        w_next  = WB;
                    end
                end
                MEM: begin
                    EXTOp   = w_ext;
                    ALUOp   = w_aluop;
                    ALUSrcA = w_srca;
                    ALUSrcB = w_srcb;
                    if (w_lw) begin
                        MemRead = 1'b1;
                        w_next  = w_ready ? WB : MEM;
                    end else if (w_sw) begin
                        MemWrite = 1'b1;
                        w_next   = w_ready ? FETCH : MEM;
                    end
                end
                WB: begin
                    EXTOp    = w_ext;
                    ALUOp    = w_aluop;
                    ALUSrcA  = w_srca;
                    ALUSrcB  = w_srcb;
                    RegWrite = 1'b1;
                    GPRSel   = w_rtype ? 2'b00 : 2'b01;
                    WDSel    = w_lw ? 2'b01 : 2'b00;
                end
                default: w_next = FETCH;
            endcase
        end
    end

    assign state = r_state;

endmodule

// File: tb/tb_mcctrl.sv
// tb/tb_mcctrl.sv - directed-vector bench for mcctrl
module tb_mcctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op, Funct;
    logic       Zero, mem_ready;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, MemRead, EXTOp;
    logic [2:0] ALUOp;
    logic [1:0] NPCOp;
    logic       ALUSrcA, ALUSrcB;
    logic [1:0] GPRSel, WDSel;
    logic [2:0] state;
    logic       illegal;

    int n_vec = 0;
    int n_err = 0;

    mcctrl #(.MEM_WAIT_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .MemRead(MemRead), .EXTOp(EXTOp), .ALUOp(ALUOp), .NPCOp(NPCOp),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .GPRSel(GPRSel), .WDSel(WDSel),
        .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // observed word: {state, PCW,IRW,RW,MW,MR,illegal, EXTOp,ALUOp,NPCOp,SrcA,SrcB, GPRSel,WDSel}
    task automatic step(input string tag, input bit r, input logic [5:0] op, input logic [5:0] fn,
                        input bit z, input bit rdy, input logic [2:0] st, input logic [5:0] en,
                        input logic [7:0] alu, input logic [3:0] sel, input bit full);
        logic [20:0] obs, exp_v, mask;
        rst = r; Op = op; Funct = fn; Zero = z; mem_ready = rdy;
        #1;
        obs   = {state, PCWrite, IRWrite, RegWrite, MemWrite, MemRead, illegal,
                 EXTOp, ALUOp, NPCOp, ALUSrcA, ALUSrcB, GPRSel, WDSel};
        exp_v = {st, en, alu, sel};
        mask  = full ? 21'h1FFFFF : 21'h1FF000;
        n_vec++;
        assert ((obs & mask) === (exp_v & mask)) else begin
            n_err++;
            $error("FAIL %s: observed %06h expected %06h (mask %06h)", tag, obs, exp_v, mask);
        end
        @(posedge clk); #1;
    endtask

    task automatic fetch(input string tag, input logic [5:0] op, input logic [5:0] fn);
        step(tag, 0, op, fn, 0, 1, 3'd0, 6'b110010, 8'h00, 4'h0, 1);
    endtask

    initial begin
        rst = 1'b1; Op = '0; Funct = '0; Zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        step("rst_hold", 1, 6'o00, 6'o00, 0, 1, 3'd0, 6'b000000, 8'h00, 4'h0, 0);

        // addu
        fetch("addu_F", 6'b000000, 6'b100001);
        step("addu_D", 0, 6'b000000, 6'b100001, 0, 1, 3'd1, 6'b000000, 8'b0_000_00_0_0, 4'b00_00, 1);
        step("addu_E", 0, 6'b000000, 6'b100001, 0, 1, 3'd2, 6'b000000, 8'b0_001_00_0_0, 4'b00_00, 1);
        step("addu_W", 0, 6'b000000, 6'b100001, 0, 1, 3'd4, 6'b001000, 8'b0_001_00_0_0, 4'b00_00, 1);

        // lw with a fetch stall and two memory wait cycles
        step("lw_Fwait", 0, 6'b100011, 6'o00, 0, 0, 3'd0, 6'b000010, 8'h00, 4'h0, 1);
        fetch("lw_F", 6'b100011, 6'o00);
        step("lw_D",  0, 6'b100011, 6'o00, 0, 1, 3'd1, 6'b000000, 8'b0_000_00_0_0, 4'b00_00, 1);
        step("lw_E",  0, 6'b100011, 6'o00, 0, 1, 3'd2, 6'b000000, 8'b1_001_00_0_1, 4'b00_00, 1);
        step("lw_M0", 0, 6'b100011, 6'o00, 0, 0, 3'd3, 6'b000010, 8'b1_001_00_0_1, 4'b00_00, 1);
        step("lw_M1", 0, 6'b100011, 6'o00, 0, 0, 3'd3, 6'b000010, 8'b1_001_00_0_1, 4'b00_00, 1);
        step("lw_M2", 0, 6'b100011, 6'o00, 0, 1, 3'd3, 6'b000010, 8'b1_001_00_0_1, 4'b00_00, 1);
        step("lw_W",  0, 6'b100011, 6'o00, 0, 1, 3'd4, 6'b001000, 8'b1_001_00_0_1, 4'b01_01, 1);

        // branches
        fetch("beq1_F", 6'b000100, 6'o00);
        step("beq1_D", 0, 6'b000100, 6'o00, 1, 1, 3'd1, 6'b000000, 8'h00, 4'h0, 1);
        step("beq1_E", 0, 6'b000100, 6'o00, 1, 1, 3'd2, 6'b100000, 8'b1_010_01_0_0, 4'h0, 1);
        fetch("beq0_F", 6'b000100, 6'o00);
        step("beq0_D", 0, 6'b000100, 6'o00, 0, 1, 3'd1, 6'b000000, 8'h00, 4'h0, 1);
        step("beq0_E", 0, 6'b000100, 6'o00, 0, 1, 3'd2, 6'b000000, 8'b1_010_01_0_0, 4'h0, 1);
        fetch("bne0_F", 6'b000101, 6'o00);
        step("bne0_D", 0, 6'b000101, 6'o00, 0, 1, 3'd1, 6'b000000, 8'h00, 4'h0, 1);
        step("bne0_E", 0, 6'b000101, 6'o00, 0, 1, 3'd2, 6'b100000, 8'b1_010_01_0_0, 4'h0, 1);

        // jumps and illegal opcode
        fetch("jal_F", 6'b000011, 6'o00);
        step("jal_D", 0, 6'b000011, 6'o00, 0, 1, 3'd1, 6'b101000, 8'b0_000_10_0_0, 4'b10_10, 1);
        fetch("j_F", 6'b000010, 6'o00);
        step("j_D",   0, 6'b000010, 6'o00, 0, 1, 3'd1, 6'b100000, 8'b0_000_10_0_0, 4'h0, 1);
        fetch("jr_F", 6'b000000, 6'b001000);
        step("jr_D",  0, 6'b000000, 6'b001000, 0, 1, 3'd1, 6'b100000, 8'b0_000_11_0_0, 4'h0, 1);
        fetch("ill_F", 6'b111111, 6'o00);
        step("ill_D", 0, 6'b111111, 6'o00, 0, 1, 3'd1, 6'b000001, 8'h00, 4'h0, 1);

        // sll and ori
        fetch("sll_F", 6'b000000, 6'b000000);
        step("sll_D", 0, 6'b000000, 6'b000000, 0, 1, 3'd1, 6'b000000, 8'h00, 4'h0, 1);
        step("sll_E", 0, 6'b000000, 6'b000000, 0, 1, 3'd2, 6'b000000, 8'b0_110_00_1_0, 4'h0, 1);
        step("sll_W", 0, 6'b000000, 6'b000000, 0, 1, 3'd4, 6'b001000, 8'b0_110_00_1_0, 4'b00_00, 1);
        fetch("ori_F", 6'b001101, 6'o00);
        step("ori_D", 0, 6'b001101, 6'o00, 0, 1, 3'd1, 6'b000000, 8'h00, 4'h0, 1);
        step("ori_E", 0, 6'b001101, 6'o00, 0, 1, 3'd2, 6'b000000, 8'b0_100_00_0_1, 4'h0, 1);
        step("ori_W", 0, 6'b001101, 6'o00, 0, 1, 3'd4, 6'b001000, 8'b0_100_00_0_1, 4'b01_00, 1);

        // sw interrupted by reset in MEM, then a clean sw
        fetch("sw_F", 6'b101011, 6'o00);
        step("sw_D",   0, 6'b101011, 6'o00, 0, 1, 3'd1, 6'b000000, 8'h00, 4'h0, 1);
        step("sw_E",   0, 6'b101011, 6'o00, 0, 1, 3'd2, 6'b000000, 8'b1_001_00_0_1, 4'h0, 1);
        step("sw_M0",  0, 6'b101011, 6'o00, 0, 0, 3'd3, 6'b000100, 8'b1_001_00_0_1, 4'h0, 1);
        step("sw_Mrst", 1, 6'b101011, 6'o00, 0, 1, 3'd3, 6'b000000, 8'h00, 4'h0, 0);
        fetch("sw2_F", 6'b101011, 6'o00);
        step("sw2_D",  0, 6'b101011, 6'o00, 0, 1, 3'd1, 6'b000000, 8'h00, 4'h0, 1);
        step("sw2_E",  0, 6'b101011, 6'o00, 0, 1, 3'd2, 6'b000000, 8'b1_001_00_0_1, 4'h0, 1);
        step("sw2_M",  0, 6'b101011, 6'o00, 0, 1, 3'd3, 6'b000100, 8'b1_001_00_0_1, 4'h0, 1);
        fetch("after_sw_F", 6'b000000, 6'b100001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
